// File: rtl/irrigacao_pkg.sv
// Shared definitions for the irrigation sequencer: state codes, default
// BCD durations and the BCD decrement helper.
package irrigacao_pkg;

  typedef enum logic [2:0] {
    ESTADO_IDLE      = 3'b000,
    ESTADO_VERIFICA  = 3'b001,
    ESTADO_GOTEJANDO = 3'b010,
    ESTADO_ASPERSAO  = 3'b011,
    ESTADO_LIMPEZA   = 3'b100,
    ESTADO_ERRO      = 3'b101
  } estado_e;

  localparam logic [7:0] T_GOTEJANDO_DEF = 8'h30;
  localparam logic [7:0] T_ASPERSAO_DEF  = 8'h15;
  localparam logic [7:0] T_LIMPEZA_DEF   = 8'h05;
  localparam logic [7:0] T_ERRO_DEF      = 8'h10;
  localparam int         RETRY_MAX_DEF   = 2;

  localparam logic [7:0] BCD_ZERO = 8'h00;
  localparam logic [7:0] BCD_ONE  = 8'h01;

  // Packed two-digit BCD minus one; a zero units digit borrows from the tens.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd0) begin
      r = {v[7:4] - 4'd1, 4'd9};
    end else begin
      r = {v[7:4], v[3:0] - 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/irrigacao_ctrl_bcd_down_counter.sv
// Two-digit BCD down counter with synchronous load, decrement enable and
// an is_one flag used to detect the last second of a timed state.
module bcd_down_counter
  import irrigacao_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  input  logic       dec_i,
  output logic [3:0] dezena_o,
  output logic [3:0] unidade_o,
  output logic       is_one_o
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Load has priority over decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i) begin
      cnt_d = bcd_dec(cnt_q);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= BCD_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign dezena_o  = cnt_q[7:4];
  assign unidade_o = cnt_q[3:0];
  assign is_one_o  = (cnt_q == BCD_ONE);

endmodule

// File: rtl/irrigacao_ctrl.sv
// Main irrigation sequencer: sensor check, drip or sprinkler run, cleaning,
// and an error hold with bounded retries ending in a latched fault.
module irrigacao_ctrl
  import irrigacao_pkg::*;
#(
  parameter logic [7:0] T_GOTEJANDO = T_GOTEJANDO_DEF,
  parameter logic [7:0] T_ASPERSAO  = T_ASPERSAO_DEF,
  parameter logic [7:0] T_LIMPEZA   = T_LIMPEZA_DEF,
  parameter logic [7:0] T_ERRO      = T_ERRO_DEF,
  parameter int         RETRY_MAX   = RETRY_MAX_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       iniciar,
  input  logic       parar,
  input  logic       umidade_baixa,
  input  logic       temp_alta,
  input  logic       nivel_vazio,
  output logic [2:0] estado,
  output logic [3:0] dezena,
  output logic [3:0] unidade,
  output logic       valvula_gotejo,
  output logic       valvula_aspersor,
  output logic       alarme,
  output logic       falha_travada
);

  localparam logic [1:0] RETRY_LIM = 2'(RETRY_MAX);

  estado_e    estado_q, estado_d;
  logic [1:0] retry_q, retry_d;
  logic       travada_q, travada_d;
  logic       gotejo_q, aspersor_q, alarme_q;

  logic       cnt_load;
  logic [7:0] cnt_val;
  logic       cnt_dec;
  logic       cnt_is_one;

  bcd_down_counter u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .dec_i      (cnt_dec),
    .dezena_o   (dezena),
    .unidade_o  (unidade),
    .is_one_o   (cnt_is_one)
  );

  // Next state, retry bookkeeping and counter commands; sensor aborts win over parar, parar over tick.
  always_comb begin
    estado_d  = estado_q;
    retry_d   = retry_q;
    travada_d = travada_q;
    cnt_load  = 1'b0;
    cnt_val   = BCD_ZERO;
    cnt_dec   = 1'b0;
    case (estado_q)
      ESTADO_IDLE: begin
        if (iniciar && !parar) begin
          estado_d = ESTADO_VERIFICA;
        end else begin
          estado_d = ESTADO_IDLE;
        end
      end
      ESTADO_VERIFICA: begin
        cnt_load = 1'b1;
        if (nivel_vazio) begin
          estado_d = ESTADO_ERRO;
          cnt_val  = T_ERRO;
        end else if (parar) begin
          estado_d = ESTADO_IDLE;
          retry_d  = 2'd0;
        end else if (temp_alta) begin
          estado_d = ESTADO_ASPERSAO;
          cnt_val  = T_ASPERSAO;
          retry_d  = 2'd0;
        end else if (umidade_baixa) begin
          estado_d = ESTADO_GOTEJANDO;
          cnt_val  = T_GOTEJANDO;
          retry_d  = 2'd0;
        end else begin
          estado_d = ESTADO_IDLE;
          retry_d  = 2'd0;
        end
      end
      ESTADO_GOTEJANDO, ESTADO_ASPERSAO: begin
        if (nivel_vazio) begin
          estado_d = ESTADO_ERRO;
          cnt_load = 1'b1;
          cnt_val  = T_ERRO;
        end else if (parar) begin
          estado_d = ESTADO_IDLE;
          cnt_load = 1'b1;
          retry_d  = 2'd0;
        end else if (tick_1hz && cnt_is_one) begin
          estado_d = ESTADO_LIMPEZA;
          cnt_load = 1'b1;
          cnt_val  = T_LIMPEZA;
        end else if (tick_1hz) begin
          cnt_dec = 1'b1;
        end else begin
          estado_d = estado_q;
        end
      end
      ESTADO_LIMPEZA: begin
        if (parar || (tick_1hz && cnt_is_one)) begin
          estado_d = ESTADO_IDLE;
          cnt_load = 1'b1;
          retry_d  = 2'd0;
        end else if (tick_1hz) begin
          cnt_dec = 1'b1;
        end else begin
          estado_d = ESTADO_LIMPEZA;
        end
      end
      ESTADO_ERRO: begin
        // Once latched, only iniciar leaves; the count stays frozen at 01.
        if (travada_q) begin
          if (iniciar) begin
            estado_d  = ESTADO_VERIFICA;
            travada_d = 1'b0;
            retry_d   = 2'd0;
            cnt_load  = 1'b1;
          end else begin
            estado_d = ESTADO_ERRO;
          end
        end else if (tick_1hz && cnt_is_one) begin
          retry_d = retry_q + 2'd1;
          if ((retry_q + 2'd1) == RETRY_LIM) begin
            travada_d = 1'b1;
          end else begin
            estado_d = ESTADO_VERIFICA;
            cnt_load = 1'b1;
          end
        end else if (tick_1hz) begin
          cnt_dec = 1'b1;
        end else begin
          estado_d = ESTADO_ERRO;
        end
      end
      default: begin
        estado_d  = ESTADO_IDLE;
        retry_d   = 2'd0;
        travada_d = 1'b0;
        cnt_load  = 1'b1;
      end
    endcase
  end

  // State, retry and output flag registers; flags track the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q   <= ESTADO_IDLE;
      retry_q    <= 2'd0;
      travada_q  <= 1'b0;
      gotejo_q   <= 1'b0;
      aspersor_q <= 1'b0;
      alarme_q   <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      retry_q    <= retry_d;
      travada_q  <= travada_d;
      gotejo_q   <= (estado_d == ESTADO_GOTEJANDO);
      aspersor_q <= (estado_d == ESTADO_ASPERSAO) || (estado_d == ESTADO_LIMPEZA);
      alarme_q   <= (estado_d == ESTADO_ERRO);
    end
  end

  assign estado           = estado_q;
  assign valvula_gotejo   = gotejo_q;
  assign valvula_aspersor = aspersor_q;
  assign alarme           = alarme_q;
  assign falha_travada    = travada_q;

endmodule

// File: tb/tb_irrigacao_ctrl.sv
// Self-checking bench for irrigacao_ctrl: directed scenarios with literal
// expectations plus a randomized run against a seconds-based reference model.
module tb_irrigacao_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       iniciar = 1'b0;
  logic       parar = 1'b0;
  logic       umidade_baixa = 1'b0;
  logic       temp_alta = 1'b0;
  logic       nivel_vazio = 1'b0;
  logic [2:0] estado;
  logic [3:0] dezena;
  logic [3:0] unidade;
  logic       valvula_gotejo;
  logic       valvula_aspersor;
  logic       alarme;
  logic       falha_travada;

  int checks = 0;
  int errors = 0;

  irrigacao_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .tick_1hz         (tick_1hz),
    .iniciar          (iniciar),
    .parar            (parar),
    .umidade_baixa    (umidade_baixa),
    .temp_alta        (temp_alta),
    .nivel_vazio      (nivel_vazio),
    .estado           (estado),
    .dezena           (dezena),
    .unidade          (unidade),
    .valvula_gotejo   (valvula_gotejo),
    .valvula_aspersor (valvula_aspersor),
    .alarme           (alarme),
    .falha_travada    (falha_travada)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: state code, remaining whole seconds, retry count, latch.
  localparam int S_IDLE = 0, S_VER = 1, S_GOT = 2, S_ASP = 3, S_LIM = 4, S_ERR = 5;
  localparam int SEC_GOT = 30, SEC_ASP = 15, SEC_LIM = 5, SEC_ERR = 10, M_RETRY_MAX = 2;

  int m_st, m_sec, m_retry;
  bit m_lat;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st = S_IDLE; m_sec = 0; m_retry = 0; m_lat = 0;
    end else begin
      case (m_st)
        S_IDLE: if (iniciar && !parar) begin m_st = S_VER; m_sec = 0; end
        S_VER: begin
          if (nivel_vazio)        begin m_st = S_ERR; m_sec = SEC_ERR; end
          else if (parar)         begin m_st = S_IDLE; m_sec = 0; m_retry = 0; end
          else if (temp_alta)     begin m_st = S_ASP; m_sec = SEC_ASP; m_retry = 0; end
          else if (umidade_baixa) begin m_st = S_GOT; m_sec = SEC_GOT; m_retry = 0; end
          else                    begin m_st = S_IDLE; m_sec = 0; m_retry = 0; end
        end
        S_GOT, S_ASP: begin
          if (nivel_vazio) begin m_st = S_ERR; m_sec = SEC_ERR; end
          else if (parar)  begin m_st = S_IDLE; m_sec = 0; m_retry = 0; end
          else if (tick_1hz) begin
            if (m_sec == 1) begin m_st = S_LIM; m_sec = SEC_LIM; end
            else m_sec = m_sec - 1;
          end
        end
        S_LIM: begin
          if (parar) begin m_st = S_IDLE; m_sec = 0; m_retry = 0; end
          else if (tick_1hz) begin
            if (m_sec == 1) begin m_st = S_IDLE; m_sec = 0; m_retry = 0; end
            else m_sec = m_sec - 1;
          end
        end
        S_ERR: begin
          if (m_lat) begin
            if (iniciar) begin m_st = S_VER; m_sec = 0; m_lat = 0; m_retry = 0; end
          end else if (tick_1hz) begin
            if (m_sec == 1) begin
              m_retry = m_retry + 1;
              if (m_retry == M_RETRY_MAX) m_lat = 1;
              else begin m_st = S_VER; m_sec = 0; end
            end else m_sec = m_sec - 1;
          end
        end
        default: begin m_st = S_IDLE; m_sec = 0; end
      endcase
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_estado",   int'(estado),           m_st);
      chk("m_dezena",   int'(dezena),           m_sec / 10);
      chk("m_unidade",  int'(unidade),          m_sec % 10);
      chk("m_gotejo",   int'(valvula_gotejo),   int'(m_st == S_GOT));
      chk("m_aspersor", int'(valvula_aspersor), int'(m_st == S_ASP || m_st == S_LIM));
      chk("m_alarme",   int'(alarme),           int'(m_st == S_ERR));
      chk("m_travada",  int'(falha_travada),    int'(m_lat));
    end
  end

  // Called at a negedge; returns at the negedge right after the n-th tick edge.
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_1hz = 1'b1;
      @(negedge clk);
      tick_1hz = 1'b0;
      if (i != n - 1) @(negedge clk);
    end
  endtask

  task automatic pulse_iniciar();
    iniciar = 1'b1;
    @(negedge clk);
    iniciar = 1'b0;
  endtask

  task automatic chk_cnt(input string nm, input int dz, input int un);
    chk({nm, "_dez"}, int'(dezena), dz);
    chk({nm, "_uni"}, int'(unidade), un);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_estado", int'(estado), 0);
    chk_cnt("rst_cnt", 0, 0);
    chk("rst_flags", int'({valvula_gotejo, valvula_aspersor, alarme, falha_travada}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Nominal drip
    umidade_baixa = 1'b1;
    pulse_iniciar();
    chk("drip_ver", int'(estado), 1);
    @(negedge clk);
    chk("drip_got", int'(estado), 2);
    chk_cnt("drip_load", 3, 0);
    chk("drip_valve", int'(valvula_gotejo), 1);
    ticks(29);
    chk_cnt("drip_last", 0, 1);
    ticks(1);
    chk("drip_lim", int'(estado), 4);
    chk_cnt("lim_load", 0, 5);
    chk("lim_gotejo_off", int'(valvula_gotejo), 0);
    ticks(5);
    chk("drip_idle", int'(estado), 0);
    chk_cnt("drip_idle", 0, 0);
    umidade_baixa = 1'b0;
    @(negedge clk);

    // Sprinkler with BCD borrow, then parar+tick at count 01
    temp_alta = 1'b1;
    pulse_iniciar();
    @(negedge clk);
    chk("asp_state", int'(estado), 3);
    chk_cnt("asp_load", 1, 5);
    ticks(5);
    chk_cnt("asp_10", 1, 0);
    ticks(1);
    chk_cnt("asp_borrow", 0, 9);
    chk("asp_valve", int'(valvula_aspersor), 1);
    ticks(8);
    chk_cnt("asp_01", 0, 1);
    parar = 1'b1; tick_1hz = 1'b1;
    @(negedge clk);
    parar = 1'b0; tick_1hz = 1'b0;
    chk("sim_parar_state", int'(estado), 0);
    chk_cnt("sim_parar", 0, 0);

    // Same collision with nivel_vazio high goes to ERRO
    pulse_iniciar();
    @(negedge clk);
    ticks(14);
    chk_cnt("asp2_01", 0, 1);
    parar = 1'b1; tick_1hz = 1'b1; nivel_vazio = 1'b1;
    @(negedge clk);
    parar = 1'b0; tick_1hz = 1'b0; nivel_vazio = 1'b0; temp_alta = 1'b0;
    chk("sim_nivel_state", int'(estado), 5);
    chk_cnt("sim_nivel", 1, 0);
    ticks(10);
    chk("err_retry_ver", int'(estado), 1);
    @(negedge clk);
    chk("err_to_idle", int'(estado), 0);

    // Mid-irrigation fault and retry exhaustion
    umidade_baixa = 1'b1;
    pulse_iniciar();
    @(negedge clk);
    ticks(3);
    chk_cnt("fault_pre", 2, 7);
    nivel_vazio = 1'b1;
    @(negedge clk);
    chk("fault_state", int'(estado), 5);
    chk_cnt("fault_cnt", 1, 0);
    chk("fault_alarme", int'(alarme), 1);
    chk("fault_gotejo", int'(valvula_gotejo), 0);
    ticks(10);
    chk("retry1_ver", int'(estado), 1);
    @(negedge clk);
    chk("retry1_err", int'(estado), 5);
    ticks(10);
    chk("latch_state", int'(estado), 5);
    chk("latch_flag", int'(falha_travada), 1);
    ticks(3);
    chk("latch_hold", int'(estado), 5);
    chk_cnt("latch_frozen", 0, 1);
    nivel_vazio = 1'b0;
    pulse_iniciar();
    chk("unlatch_ver", int'(estado), 1);
    chk("unlatch_flag", int'(falha_travada), 0);
    @(negedge clk);
    chk("unlatch_got", int'(estado), 2);

    // Async reset in the middle of LIMPEZA
    ticks(30);
    ticks(2);
    chk("prereset_lim", int'(estado), 4);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_estado", int'(estado), 0);
    chk_cnt("areset_cnt", 0, 0);
    chk("areset_flags", int'({valvula_gotejo, valvula_aspersor, alarme, falha_travada}), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("postreset_idle", int'(estado), 0);

    // Randomized run against the model
    umidade_baixa = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      iniciar  = ($urandom_range(0, 9) == 0);
      parar    = ($urandom_range(0, 59) == 0);
      tick_1hz = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 39) == 0) nivel_vazio = ~nivel_vazio;
      if ($urandom_range(0, 19) == 0) temp_alta = ~temp_alta;
      if ($urandom_range(0, 9) == 0) umidade_baixa = ~umidade_baixa;
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
